// File: rtl/stack_cmd_issuer_if.sv
// Host command / result bus and stack-side opcode port of the stack command issuer.
// Latency: n/a (signal bundle only).
// Backpressure: cmd_valid/cmd_ready on commands; results and stack port have none.
// Ports: cmd_* host commands in; res_* result pulses out; err/err_code drops;
//        occupancy shadow count; st_* drive and observe the stack ALU.
interface stack_cmd_issuer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16
);
    localparam int OCC_W = $clog2(STACK_DEPTH + 1);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  res_valid;
    logic [2:0]            res_op;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_ovf;
    logic                  err;
    logic [1:0]            err_code;
    logic [OCC_W-1:0]      occupancy;
    logic [2:0]            st_opcode;
    logic [DATA_WIDTH-1:0] st_data_in;
    logic [DATA_WIDTH-1:0] st_data_out;
    logic                  st_overflow;

    // Issuer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, st_data_out, st_overflow,
        output cmd_ready, res_valid, res_op, res_data, res_ovf, err, err_code,
               occupancy, st_opcode, st_data_in
    );

    // Host + stack side
    modport master (
        output cmd_valid, cmd_op, cmd_data, st_data_out, st_overflow,
        input  cmd_ready, res_valid, res_op, res_data, res_ovf, err, err_code,
               occupancy, st_opcode, st_data_in
    );
endinterface

// File: rtl/stack_cmd_issuer.sv
// Buffers host stack commands, screens them against a shadow occupancy and issues them to the stack ALU.
// Latency: accept at E, st_opcode during E+1..E+2, res_valid during E+3..E+4 (add/mul/pop).
// Backpressure: cmd_ready = command FIFO not full; result/err pulses cannot be stalled.
// Ports: clk, rst (async active-low), bus (stack_cmd_issuer_if.slave: cmd_*, res_*, err*, occupancy, st_*).
module stack_cmd_issuer #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    stack_cmd_issuer_if.slave   bus
);
    localparam int OCC_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] ERR_UNDER   = 2'b01;
    localparam logic [1:0] ERR_FULL    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    typedef struct packed {
        logic [2:0]            op;
        logic [DATA_WIDTH-1:0] dat;
    } cmd_t;

    state_t                state_q, state_d;
    cmd_t                  fifo_mem_q [FIFO_DEPTH];
    cmd_t                  fifo_mem_d [FIFO_DEPTH];
    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]            op_q, op_d;
    logic [2:0]            st_opcode_q, st_opcode_d;
    logic [DATA_WIDTH-1:0] st_data_in_q, st_data_in_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  res_valid_q, res_valid_d;
    logic [2:0]            res_op_q, res_op_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_ovf_q, res_ovf_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    logic fifo_full;
    logic fifo_empty;
    logic cmd_wr;
    cmd_t head;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign cmd_wr     = bus.cmd_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        if (cmd_wr) begin
            fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = '{op: bus.cmd_op, dat: bus.cmd_data};
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        op_d         = op_q;
        st_opcode_d  = st_opcode_q;
        st_data_in_d = st_data_in_q;
        occ_d        = occ_q;
        res_valid_d  = 1'b0;
        res_op_d     = res_op_q;
        res_data_d   = res_data_q;
        res_ovf_d    = res_ovf_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_ptr_d = rd_ptr_q + CNT_W'(1);
                    case (head.op)
                        OP_NOP: ;
                        OP_ADD, OP_MUL: begin
                            if (occ_q < OCC_W'(2)) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_UNDER;
                            end else begin
                                state_d = ISSUE;
                            end
                        end
                        OP_PUSH: begin
                            if (occ_q == OCC_W'(STACK_DEPTH)) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_FULL;
                            end else begin
                                state_d = ISSUE;
                            end
                        end
                        OP_POP: begin
                            if (occ_q == '0) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_UNDER;
                            end else begin
                                state_d = ISSUE;
                            end
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_ILLEGAL;
                        end
                    endcase
                    if (state_d == ISSUE) begin
                        op_d         = head.op;
                        st_opcode_d  = head.op;
                        st_data_in_d = (head.op == OP_PUSH) ? head.dat : '0;
                    end
                end
            end
            ISSUE: begin
                // The stack executes on this edge; the opcode must drop back to nop.
                st_opcode_d  = OP_NOP;
                st_data_in_d = '0;
                if (op_q == OP_PUSH) begin
                    occ_d   = occ_q + OCC_W'(1);
                    state_d = IDLE;
                end else begin
                    occ_d   = occ_q - OCC_W'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                res_valid_d = 1'b1;
                res_op_d    = op_q;
                res_data_d  = bus.st_data_out;
                res_ovf_d   = bus.st_overflow;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            op_q         <= OP_NOP;
            st_opcode_q  <= OP_NOP;
            st_data_in_q <= '0;
            occ_q        <= '0;
            res_valid_q  <= 1'b0;
            res_op_q     <= OP_NOP;
            res_data_q   <= '0;
            res_ovf_q    <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            op_q         <= op_d;
            st_opcode_q  <= st_opcode_d;
            st_data_in_q <= st_data_in_d;
            occ_q        <= occ_d;
            res_valid_q  <= res_valid_d;
            res_op_q     <= res_op_d;
            res_data_q   <= res_data_d;
            res_ovf_q    <= res_ovf_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.cmd_ready  = !fifo_full;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_op     = res_op_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_ovf    = res_ovf_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.occupancy  = occ_q;
    assign bus.st_opcode  = st_opcode_q;
    assign bus.st_data_in = st_data_in_q;
endmodule
